// File: rtl/acc_seq_gen.sv
// acc_seq_gen: start-triggered arithmetic sequence generator feeding acc_core.
// Produces a run-framed stream of valid beats number = base + k*step (k = 0..len-1,
// wrapping modulo 2^IN_DATA_WIDTH), honours a pause input while streaming and
// emits a one-cycle done pulse at the end of every accepted start.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   start_i   - start request, sampled only when idle
//   len_i     - beat count, latched on accepted start (0 = immediate done)
//   base_i    - first value, latched on accepted start
//   step_i    - increment between beats, latched on accepted start
//   pause_i   - suppresses beat issue while streaming
//   busy_o    - high whenever a sequence is in progress
//   run_o     - frame to acc_core.run_i
//   valid_o   - beat strobe to acc_core.valid_i
//   number_o  - beat value to acc_core.number_i
//   done_o    - one-cycle completion pulse
module acc_seq_gen #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [CNT_WIDTH-1:0]     len_i,
  input  logic [IN_DATA_WIDTH-1:0] base_i,
  input  logic [IN_DATA_WIDTH-1:0] step_i,
  input  logic                     pause_i,
  output logic                     busy_o,
  output logic                     run_o,
  output logic                     valid_o,
  output logic [IN_DATA_WIDTH-1:0] number_o,
  output logic                     done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     len_q, len_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [IN_DATA_WIDTH-1:0] step_q, step_d;
  logic [IN_DATA_WIDTH-1:0] val_q, val_d;
  logic                     busy_q, busy_d;
  logic                     run_q, run_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic [IN_DATA_WIDTH-1:0] number_q, number_d;
  logic [CNT_WIDTH-1:0]     cnt_inc;

  assign cnt_inc = cnt_q + CNT_WIDTH'(1);

  // Outputs are registered from the current state, so they trail the state
  // register by one cycle: start at edge n shows ARM outputs after edge n+1.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    val_d    = val_q;
    number_d = number_q;
    busy_d   = 1'b0;
    run_d    = 1'b0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            len_d   = len_i;
            val_d   = base_i;
            step_d  = step_i;
            cnt_d   = '0;
            state_d = S_ARM;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ARM: begin
        busy_d  = 1'b1;
        run_d   = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        busy_d = 1'b1;
        run_d  = 1'b1;
        // A paused cycle holds counter, running value and number_o.
        if (!pause_i) begin
          valid_d  = 1'b1;
          number_d = val_q;
          val_d    = val_q + step_q;
          cnt_d    = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy_d  = 1'b1;
        run_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched parameters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      val_q    <= '0;
      number_q <= '0;
      busy_q   <= 1'b0;
      run_q    <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      val_q    <= val_d;
      number_q <= number_d;
      busy_q   <= busy_d;
      run_q    <= run_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign run_o    = run_q;
  assign valid_o  = valid_q;
  assign number_o = number_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_acc_seq_gen.sv
// Directed bench for acc_seq_gen: per-cycle checks of {busy,run,valid,done,number}.
module tb_acc_seq_gen;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [7:0] len_i;
  logic [7:0] base_i;
  logic [7:0] step_i;
  logic       pause_i;
  logic       busy_o;
  logic       run_o;
  logic       valid_o;
  logic [7:0] number_o;
  logic       done_o;

  int checks;
  int failures;
  int sum;

  acc_seq_gen #(.IN_DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .len_i    (len_i),
    .base_i   (base_i),
    .step_i   (step_i),
    .pause_i  (pause_i),
    .busy_o   (busy_o),
    .run_o    (run_o),
    .valid_o  (valid_o),
    .number_o (number_o),
    .done_o   (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the packed output vector {busy,run,valid,done,number}.
  task automatic chk(input string tag, input logic b, input logic r, input logic v,
                     input logic d, input logic [7:0] n);
    logic [11:0] obs;
    logic [11:0] exp;
    obs = {busy_o, run_o, valid_o, done_o, number_o};
    exp = {b, r, v, d, n};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed b/r/v/d/num=%b/%b/%b/%b/%0d expected=%b/%b/%b/%b/%0d",
             tag, obs[11], obs[10], obs[9], obs[8], obs[7:0], b, r, v, d, n);
    end
  endtask

  task automatic step_chk(input string tag, input logic b, input logic r, input logic v,
                          input logic d, input logic [7:0] n);
    tick();
    chk(tag, b, r, v, d, n);
  endtask

  task automatic go(input logic [7:0] len, input logic [7:0] base, input logic [7:0] step);
    len_i   = len;
    base_i  = base;
    step_i  = step;
    start_i = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sum      = 0;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    len_i    = '0;
    base_i   = '0;
    step_i   = '0;
    pause_i  = 1'b0;

    // Reset state
    #12;
    chk("reset_hold", 0, 0, 0, 0, 8'd0);
    tick();
    rst_n = 1'b1;
    step_chk("after_reset", 0, 0, 0, 0, 8'd0);

    // Wrap-around: 250, 253, 0, 3
    go(8'd4, 8'd250, 8'd3);
    step_chk("wrap_accept", 0, 0, 0, 0, 8'd0);
    start_i = 1'b0;
    base_i  = 8'd77;
    step_chk("wrap_arm", 1, 1, 0, 0, 8'd0);
    step_chk("wrap_b0", 1, 1, 1, 0, 8'd250);
    step_chk("wrap_b1", 1, 1, 1, 0, 8'd253);
    step_chk("wrap_b2", 1, 1, 1, 0, 8'd0);
    step_chk("wrap_b3", 1, 1, 1, 0, 8'd3);
    step_chk("wrap_drain", 1, 1, 0, 0, 8'd3);
    step_chk("wrap_done", 1, 0, 0, 1, 8'd3);
    step_chk("wrap_idle", 0, 0, 0, 0, 8'd3);

    // Pause mid-stream: 5, 10, two paused cycles, 15, 20
    go(8'd4, 8'd5, 8'd5);
    step_chk("pause_accept", 0, 0, 0, 0, 8'd3);
    start_i = 1'b0;
    step_chk("pause_arm", 1, 1, 0, 0, 8'd3);
    step_chk("pause_b0", 1, 1, 1, 0, 8'd5);
    step_chk("pause_b1", 1, 1, 1, 0, 8'd10);
    pause_i = 1'b1;
    step_chk("pause_p0", 1, 1, 0, 0, 8'd10);
    step_chk("pause_p1", 1, 1, 0, 0, 8'd10);
    pause_i = 1'b0;
    step_chk("pause_b2", 1, 1, 1, 0, 8'd15);
    step_chk("pause_b3", 1, 1, 1, 0, 8'd20);
    pause_i = 1'b1;
    step_chk("pause_drain", 1, 1, 0, 0, 8'd20);
    step_chk("pause_done", 1, 0, 0, 1, 8'd20);
    pause_i = 1'b0;
    step_chk("pause_idle", 0, 0, 0, 0, 8'd20);

    // Zero length
    go(8'd0, 8'd9, 8'd9);
    step_chk("zero_accept", 0, 0, 0, 0, 8'd20);
    start_i = 1'b0;
    step_chk("zero_done", 1, 0, 0, 1, 8'd20);
    step_chk("zero_idle", 0, 0, 0, 0, 8'd20);
    step_chk("zero_idle2", 0, 0, 0, 0, 8'd20);

    // Start while busy is ignored; start after done is accepted
    go(8'd3, 8'd1, 8'd2);
    step_chk("busy_accept", 0, 0, 0, 0, 8'd20);
    start_i = 1'b0;
    step_chk("busy_arm", 1, 1, 0, 0, 8'd20);
    step_chk("busy_b0", 1, 1, 1, 0, 8'd1);
    go(8'd7, 8'd100, 8'd1);
    step_chk("busy_b1", 1, 1, 1, 0, 8'd3);
    start_i = 1'b0;
    step_chk("busy_b2", 1, 1, 1, 0, 8'd5);
    step_chk("busy_drain", 1, 1, 0, 0, 8'd5);
    step_chk("busy_done", 1, 0, 0, 1, 8'd5);
    start_i = 1'b1;
    step_chk("next_accept", 0, 0, 0, 0, 8'd5);
    start_i = 1'b0;
    step_chk("next_arm", 1, 1, 0, 0, 8'd5);
    for (int k = 0; k < 7; k++) begin
      step_chk("next_beat", 1, 1, 1, 0, 8'(100 + k));
    end
    step_chk("next_drain", 1, 1, 0, 0, 8'd106);
    step_chk("next_done", 1, 0, 0, 1, 8'd106);
    step_chk("next_idle", 0, 0, 0, 0, 8'd106);

    // Base sequence 1..100, sum of beats 5050
    go(8'd100, 8'd1, 8'd1);
    step_chk("seq_accept", 0, 0, 0, 0, 8'd106);
    start_i = 1'b0;
    step_chk("seq_arm", 1, 1, 0, 0, 8'd106);
    for (int k = 1; k <= 100; k++) begin
      step_chk("seq_beat", 1, 1, 1, 0, 8'(k));
      if (valid_o) sum += int'(number_o);
    end
    step_chk("seq_drain", 1, 1, 0, 0, 8'd100);
    step_chk("seq_done", 1, 0, 0, 1, 8'd100);
    step_chk("seq_idle", 0, 0, 0, 0, 8'd100);
    checks++;
    assert (sum === 5050) else begin
      failures++;
      $error("FAIL seq_sum observed=%0d expected=5050", sum);
    end

    // Reset mid-stream after beat 10, then a clean len=2 run
    go(8'd100, 8'd1, 8'd1);
    step_chk("rst_accept", 0, 0, 0, 0, 8'd100);
    start_i = 1'b0;
    step_chk("rst_arm", 1, 1, 0, 0, 8'd100);
    for (int k = 1; k <= 10; k++) begin
      step_chk("rst_beat", 1, 1, 1, 0, 8'(k));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 0, 0, 0, 0, 8'd0);
    step_chk("rst_held", 0, 0, 0, 0, 8'd0);
    rst_n = 1'b1;
    step_chk("rst_release", 0, 0, 0, 0, 8'd0);
    go(8'd2, 8'd7, 8'd9);
    step_chk("post_accept", 0, 0, 0, 0, 8'd0);
    start_i = 1'b0;
    step_chk("post_arm", 1, 1, 0, 0, 8'd0);
    step_chk("post_b0", 1, 1, 1, 0, 8'd7);
    step_chk("post_b1", 1, 1, 1, 0, 8'd16);
    step_chk("post_drain", 1, 1, 0, 0, 8'd16);
    step_chk("post_done", 1, 0, 0, 1, 8'd16);
    step_chk("post_idle", 0, 0, 0, 0, 8'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_seq_gen.md
# acc_seq_gen

Upstream stimulus/sequence generator for `acc_core`. On a start command it produces the `run`/`valid`/`number` stream that `acc_core` consumes: an arithmetic sequence of programmable base, step and length, framed by `run`. It also emits a completion pulse, so a controller can sequence repeated accumulations without a hand-written bench.

## Interface
- `IN_DATA_WIDTH`, default 8: width of `number_o`, `base_i` and `step_i`; matches `acc_core` `IN_DATA_WIDTH`.
- `CNT_WIDTH`, default 8: width of `len_i` and the internal beat counter.
- `clk` input, 1: single clock; all logic is rising-edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start_i` input, 1: start request; sampled only in IDLE.
- `len_i` input, CNT_WIDTH: number of beats to issue; latched on accepted start.
- `base_i` input, IN_DATA_WIDTH: first value; latched on accepted start.
- `step_i` input, IN_DATA_WIDTH: increment between beats; latched on accepted start.
- `pause_i` input, 1: suppresses beat issue while high (STREAM only).
- `busy_o` output, 1: high in every state except IDLE.
- `run_o` output, 1: drives `acc_core.run_i`.
- `valid_o` output, 1: drives `acc_core.valid_i`.
- `number_o` output, IN_DATA_WIDTH: drives `acc_core.number_i`.
- `done_o` output, 1: one-cycle pulse at sequence end.

## Operation
- States: IDLE, ARM, STREAM, DRAIN, DONE. All outputs are registered.
- **IDLE**
  - `run_o`, `valid_o` and `done_o` are 0.
  - `start_i`=1 with `len_i`≠0: latch `len`, `base`, `step`; clear the beat counter; go to ARM.
  - `start_i`=1 with `len_i`=0: go directly to DONE; `run_o` and `valid_o` are never asserted.
- **ARM** (exactly 1 cycle)
  - `run_o`=1, `valid_o`=0.
  - Next state is STREAM.
- **STREAM**
  - Each cycle with `pause_i`=0 issues one beat: `valid_o`=1, `number_o` = base + k·step, where k is the beat index from 0.
  - Sum is truncated to IN_DATA_WIDTH, i.e. wraps modulo 2^IN_DATA_WIDTH.
  - Beat counter increments per issued beat. When the counter reaches `len`, go to DRAIN.
- **Pause**
  - `pause_i`=1 in STREAM: no beat issued, `valid_o`=0, `number_o` holds its last value, `run_o` stays 1, counter holds.
  - `pause_i` is ignored in all other states.
- **DRAIN** (exactly 1 cycle)
  - `run_o`=1, `valid_o`=0. This lets `acc_core` absorb the final beat.
- **DONE** (exactly 1 cycle)
  - `run_o`=0, `done_o`=1.
  - Next state is IDLE.
- **Start while busy:** `start_i` is ignored. Latched parameters do not change mid-sequence.
- **Mid-operation input changes:** `len_i`, `base_i` and `step_i` may change freely after start; they have no effect until the next accepted start.
- **`number_o` outside STREAM beats:** holds its last driven value. It is 0 after reset.

## Timing
- **Reset:**
  - Asynchronous assertion forces IDLE at once.
  - All outputs are 0 during and after reset: `busy_o`, `run_o`, `valid_o`, `number_o`, `done_o`.
  - Reset mid-sequence aborts with no `done_o` pulse.
- **Start to first beat:** `start_i` sampled at edge n (IDLE).
  - After edge n+1: ARM; `run_o`=1, `busy_o`=1.
  - After edge n+2: first beat, `valid_o`=1, `number_o`=base.
- **Throughput and end of sequence:** with no pause, `len` consecutive valid cycles.
  - Last beat is in the cycle after edge n+1+len.
  - DRAIN is the next cycle; DONE (`done_o`=1, `run_o`=0) follows it.
  - The next `start_i` is accepted at the edge that leaves DONE, when the FSM is in IDLE.
- **Pause latency:** `pause_i`=1 sampled at edge m suppresses the beat in the cycle after edge m. Each paused cycle adds exactly one cycle to the sequence.
- **`len_i`=0:** `start_i` at edge n gives `done_o`=1 after edge n+1 and IDLE after edge n+2.
- **Framing:** `run_o` spans ARM through DRAIN, i.e. len+2 cycles plus paused cycles. `valid_o` is never high outside STREAM.

## Test plan
- **Base sequence into `acc_core`:** base=1, step=1, len=100, no pause.
  - `number_o` = 1..100 on 100 consecutive valid cycles.
  - `run_o` frames them with one leading and one trailing cycle.
  - `acc_core.result_o` = 5050; exactly one `done_o` pulse.
- **Wrap-around:** base=250, step=3, len=4 → `number_o` = 250, 253, 0, 3; then DRAIN and DONE.
- **Pause mid-stream:** base=5, step=5, len=4; `pause_i` high for 2 cycles after the 2nd beat.
  - Beats are 5, 10, (2 idle cycles with `run_o`=1, `valid_o`=0), 15, 20.
  - `done_o` arrives 2 cycles later than the unpaused case.
- **Zero length:** len=0 → `run_o` and `valid_o` stay 0; `done_o`=1 one cycle after start; `busy_o` high for 1 cycle only.
- **Start while busy:** second `start_i` with len=7 issued during STREAM of a len=3 run.
  - Exactly 3 beats are issued and the second start is ignored.
  - A start issued after `done_o` is accepted and produces 7 beats.
- **Reset mid-stream:** `rst_n` low after beat 10 of a len=100 run.
  - All outputs are 0 immediately, with no `done_o`.
  - After release, a new start with len=2 produces 2 beats normally.
